// File: rtl/pe_alu_pkg.sv
// Shared op codes and the reference ALU function for the PE pipelined ALU.
// The function works at the maximum legal width; callers truncate to their WIDTH.
package pe_alu_pkg;

  localparam int MAX_WIDTH = 64;

  localparam logic [2:0] OP_ADD     = 3'b000;
  localparam logic [2:0] OP_SUB     = 3'b001;
  localparam logic [2:0] OP_AND     = 3'b010;
  localparam logic [2:0] OP_OR      = 3'b011;
  localparam logic [2:0] OP_XOR     = 3'b100;
  localparam logic [2:0] OP_MUL     = 3'b101;
  localparam logic [2:0] OP_SEL     = 3'b110;
  localparam logic [2:0] OP_MUL_ADD = 3'b111;

  // Truncating the result to the caller's width is exact for every op: the low
  // bits of add/sub/mul depend only on the low bits of the operands.
  function automatic logic [MAX_WIDTH-1:0] alu_eval(
    input logic [2:0]           op,
    input logic [MAX_WIDTH-1:0] a,
    input logic [MAX_WIDTH-1:0] b,
    input logic                 sel,
    input logic [MAX_WIDTH-1:0] acc_in
  );
    logic [MAX_WIDTH-1:0] result;
    // NOTE: assign a default before the case so every path drives result;
    // the same habit in always_comb is what keeps latches from being inferred.
    result = '0;
    case (op)
      OP_ADD:     result = a + b;
      OP_SUB:     result = a - b;
      OP_AND:     result = a & b;
      OP_OR:      result = a | b;
      OP_XOR:     result = a ^ b;
      OP_MUL:     result = a * b;
      OP_SEL:     result = sel ? a : b;
      OP_MUL_ADD: result = acc_in + a * b;
      default:    result = '0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/pe_alu_core.sv
// Combinational ALU evaluator: widens operands, evaluates, truncates to WIDTH.
module pe_alu_core
  import pe_alu_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int NoConfigBits = 3
) (
  input  logic [NoConfigBits-1:0] op,
  input  logic [WIDTH-1:0]        a,
  input  logic [WIDTH-1:0]        b,
  input  logic                    sel,
  input  logic [WIDTH-1:0]        acc_in,
  output logic [WIDTH-1:0]        result
);

  assign result = WIDTH'(alu_eval(3'(op), MAX_WIDTH'(a), MAX_WIDTH'(b), sel,
                                  MAX_WIDTH'(acc_in)));

endmodule

// File: rtl/pe_alu_pipe.sv
// Two-stage valid/ready ALU for the PE tile: operand capture, then compute and
// result register, with a running accumulator for MUL_ADD.
module pe_alu_pipe
  import pe_alu_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int NoConfigBits = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        data_in1,
  input  logic [WIDTH-1:0]        data_in2,
  input  logic                    data_in3,
  input  logic                    acc_clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        data_out,
  output logic                    zero_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic [NoConfigBits-1:0] ALU_func
);

  logic             stall;
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_sel;
  logic             s1_clr;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_in;
  logic [WIDTH-1:0] f;
  logic             op_is_mac;

  // A held result blocks both stages, so nothing advances until it drains.
  assign stall     = out_valid & ~out_ready;
  assign in_ready  = ~stall;
  assign acc_in    = s1_clr ? '0 : acc;
  assign op_is_mac = (3'(ALU_func) == OP_MUL_ADD);

  pe_alu_core #(
    .WIDTH        (WIDTH),
    .NoConfigBits (NoConfigBits)
  ) u_core (
    .op     (ALU_func),
    .a      (s1_a),
    .b      (s1_b),
    .sel    (s1_sel),
    .acc_in (acc_in),
    .result (f)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and stage order in the source does not matter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (!stall) begin
      s1_valid <= in_valid;
    end
  end

  // NOTE: operand registers are only consumed when s1_valid is set, so they
  // carry no reset; only the valid bit and architectural state need one.
  always_ff @(posedge clk) begin
    if (!stall) begin
      s1_a   <= data_in1;
      s1_b   <= data_in2;
      s1_sel <= data_in3;
      s1_clr <= acc_clear;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      data_out  <= '0;
      zero_out  <= 1'b0;
      acc       <= '0;
    end else if (!stall) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        data_out <= f;
        zero_out <= (f == '0);
        if (op_is_mac) acc <= f;
      end
    end
  end

endmodule

// File: doc/pe_alu_pipe.md
Name: pe_alu_pipe

Overview:
- Pipelined, handshaked successor to the PE combinational ALU, sitting in the PE tile between the operand routing muxes and the PE output register bank.
- Two-stage datapath: operand capture, then compute and result register.
- Adds a running accumulator for MUL_ADD, bitwise AND/OR and a zero flag.
- Backpressure is a valid/ready pair on each side, so PEs can be chained without external FIFOs.

Parameters:
- WIDTH, 32, datapath width of operands, result and accumulator (legal values 8..64).
- NoConfigBits, 3, width of the ALU_func configuration field.

Ports:
- clk  input  1  user clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- data_in1  input  WIDTH  operand A.
- data_in2  input  WIDTH  operand B.
- data_in3  input  1  select bit for SEL.
- acc_clear  input  1  sampled with the input beat; in MUL_ADD, restarts the accumulation.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts the beat this cycle.
- data_out  output  WIDTH  registered result.
- zero_out  output  1  registered; 1 when data_out == 0.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- ALU_func  input  NoConfigBits  config bits, FEATURE="ADD;SUB;AND;OR;XOR;MUL;MUL_ADD;SEL", static during operation.

Behaviour:
- Encoding of ALU_func:
  - 000 ADD
  - 001 SUB
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 MUL
  - 110 SEL (data_in3 ? A : B)
  - 111 MUL_ADD
- Reset (asynchronous, active-high): s1_valid, out_valid, data_out, zero_out and acc all 0. in_ready = 1 during reset-deassert cycle and after.
- Stall condition: stall = out_valid & ~out_ready.
  - in_ready = ~stall (combinational).
  - Accepted beat: in_valid & in_ready.
- Stage 1, when not stalled: registers A, B, data_in3 and acc_clear; s1_valid <= in_valid.
- Stage 2, when not stalled: out_valid <= s1_valid. If s1_valid, data_out <= f(s1 operands) and zero_out <= (f == 0).
- Latency: exactly 2 cycles from acceptance to out_valid with no stall. Throughput 1 beat/cycle while out_ready = 1.
- Arithmetic:
  - All results are truncated modulo 2^WIDTH and treated as unsigned.
  - MUL keeps the low WIDTH bits of the 2*WIDTH product.
  - SUB wraps, e.g. 0 - 1 = all ones.
- MUL_ADD:
  - f = (s1_acc_clear ? 0 : acc) + A*B, truncated.
  - acc <= f in the same edge stage 2 captures a MUL_ADD result.
  - acc is unchanged by all other ops and by bubbles.
- Stall: all state (s1, data_out, acc) is held. out_valid stays 1 and data_out stays stable until out_ready. No beat is lost or duplicated.
- Simultaneous drain and accept: when out_ready = 1 while out_valid = 1, a new beat is accepted in the same cycle (no bubble).
- Reset mid-operation: in-flight beats are discarded and acc is cleared. No output is produced for them.
- Reserved: none; all 8 encodings are defined. ALU_func changes while beats are in flight are illegal and produce an undefined result, but must not deadlock.

Decomposition:
- Package pe_alu_pkg:
  - localparams for the eight op codes;
  - function alu_eval(op, a, b, sel, acc_in) returning a WIDTH result.
- One natural sub-module: pe_alu_core, the combinational evaluator. pe_alu_pipe owns the handshake, pipeline registers and accumulator.

Test Plan:
- Reset then ADD: A=5, B=7, in_valid held 1 cycle, out_ready=1 -> out_valid exactly 2 cycles later, data_out=12, zero_out=0.
- SUB wrap, WIDTH=32: A=0, B=1 -> data_out=0xFFFFFFFF. Then XOR A=B=0xA5A5A5A5 -> data_out=0, zero_out=1.
- MUL_ADD stream:
  - beats (3,4,clear=1), (2,5,clear=0), (1,1,clear=0) -> outputs 12, 22, 23;
  - a fourth beat (6,6,clear=1) -> 36.
- Backpressure: stream 4 ADD beats with out_ready=0 for 3 cycles after the first result.
  - data_out held constant and in_ready=0 while stalled;
  - all 4 results delivered in order with none dropped.
- Reset mid-stream: assert rst with 2 beats in flight during MUL_ADD -> out_valid=0 and acc=0 immediately. Next beat (2,3,clear=0) -> 6.
- SEL and MUL, WIDTH=8:
  - SEL with data_in3=1, A=0x11, B=0x22 -> 0x11;
  - MUL A=0x10, B=0x10 -> 0x00 (truncated), zero_out=1.
